instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: IMEM_DEPTH, 2048, instruction memory size in bytes.
REQ-002 SHALL have parameter: ADDR_W, 11, write address width, equal to log2(IMEM_DEPTH).
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  in  1  instruction fields present.
REQ-006 SHALL have port: in_ready  out  1  encoder can accept an instruction.
REQ-007 SHALL have ports: icode  in  4,  ifun  in  4,  rA  in  4,  rB  in  4,  valC  in  64  Y86-64 instruction fields.
REQ-008 SHALL have port: set_addr  in  1  load the write pointer from new_addr.
REQ-009 SHALL have port: new_addr  in  ADDR_W  new write pointer value.
REQ-010 SHALL have ports: wr_en  out  1,  wr_addr  out  ADDR_W,  wr_data  out  8  byte write to instruction memory.
REQ-011 SHALL have port: wr_ptr  out  ADDR_W  next free byte address.
REQ-012 SHALL have port: done  out  1  one-cycle pulse when the last byte of an instruction is written.
REQ-013 SHALL have ports: err  out  1  one-cycle rejection pulse;  err_code  out  2  rejection cause: 1 = bad icode, 2 = overflow, 3 = bad field.

Function
REQ-014 SHALL implement FSM IDLE -> EMIT -> IDLE; in_ready = 1 only in IDLE and not in reset.
REQ-015 SHALL accept an instruction on in_valid && in_ready and latch all fields; input fields SHALL be ignored while in EMIT.
REQ-016 SHALL set instruction length from icode: 0/1/9 -> 1; 2/6/10/11 -> 2; 7/8 -> 9; 3/4/5 -> 10.
REQ-017 SHALL emit byte0 = {icode, ifun}.
REQ-018 SHALL emit the register byte {rA, rB} as byte1 for icodes 2, 3, 4, 5, 6, 10 and 11.
REQ-019 SHALL emit valC most-significant byte first: bytes 2..9 for icodes 3/4/5; bytes 1..8 for icodes 7/8.
REQ-020 SHALL write byte k of an accepted instruction at wr_ptr+k, with wr_en high, in cycle k+1 after acceptance; one byte per cycle, with no gaps.
REQ-021 SHALL pulse done in the same cycle as the last byte is written, advance wr_ptr by the instruction length on that edge, and return to IDLE.
REQ-022 SHALL reject icode > 11 on acceptance: err = 1 and err_code = 1 in the next cycle, no writes, wr_ptr unchanged, state stays IDLE.
REQ-023 SHALL reject an instruction whose last byte address would exceed IMEM_DEPTH-1: err_code = 2, no writes; wr_ptr SHALL never wrap.
REQ-024 SHALL apply set_addr only in IDLE; set_addr SHALL be ignored in EMIT.
REQ-025 SHALL, when set_addr and acceptance coincide, load the pointer first and encode the instruction starting at new_addr.
REQ-026 SHALL drive wr_en, done and err to 0 in every cycle not specified above; wr_addr and wr_data are don't-care when wr_en = 0.

Reset
REQ-027 SHALL on rst force state IDLE, wr_ptr = 0, wr_en = 0, done = 0, err = 0, err_code = 0 and in_ready = 0, asynchronously.
REQ-028 SHALL, on reset during EMIT, abort immediately; bytes already written remain in memory, and no done pulse is issued.
REQ-029 SHALL assert in_ready in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL compile field checks only when INSTR_ENC_REGCHK_EN is defined.
REQ-031 With INSTR_ENC_REGCHK_EN defined, SHALL reject with err_code = 3: irmovq with rA != 0xF; pushq/popq with rB != 0xF; OPq with ifun > 3; jXX/cmovXX with ifun > 6; any other icode with ifun != 0.
REQ-032 Without INSTR_ENC_REGCHK_EN, SHALL encode fields unchecked, and err_code 3 SHALL never occur.
REQ-033 Priority of rejection causes SHALL be bad icode > bad field > overflow.

Structure
REQ-034 SHALL place icode constants (HALT..POPQ), the RNONE = 0xF constant, the length lookup function and the err_code enum in shared package y86_pkg, which is also used by fetch.
REQ-035 SHALL use one sub-module, instr_len, a combinational icode -> length and validity decoder; all sequencing stays in instr_encoder.

Verification
REQ-036 After reset, irmovq (icode 3, ifun 0, rA F, rB 0, valC 4) -> bytes 0x30, 0xF0, 0x00 x7, 0x04 at addresses 0..9 in cycles 1..10; done pulses in cycle 10; wr_ptr = 10.
REQ-037 nop then halt, back-to-back -> 0x10 at address 10 and 0x00 at address 11; in_ready is low for exactly one cycle per instruction; wr_ptr = 12.
REQ-038 addq %rax,%rbx (icode 6, ifun 0, rA 0, rB 3) with set_addr = 1 and new_addr = 23 in the same cycle -> 0x60 at 23 and 0x03 at 24; wr_ptr = 25.
REQ-039 icode 0xC -> err = 1 with err_code = 1 one cycle later, no wr_en, wr_ptr unchanged. Then set_addr 2045 followed by a jXX -> err_code = 2, no writes.
REQ-040 rst asserted while byte 4 of an irmovq is being written -> wr_en = 0 at once, wr_ptr = 0, no done pulse; in_ready = 1 in the cycle after release.
REQ-041 With INSTR_ENC_REGCHK_EN defined, pushq with rB = 0 -> err_code = 3 and no writes; without the macro, the same input writes 0xA0, 0x00.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, register sentinel, instruction length lookup
// and the encoder rejection codes.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE  = 4'hF;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrIcode    = 2'd1,
    ErrOverflow = 2'd2,
    ErrField    = 2'd3
  } err_code_e;

  // Length in bytes; 0 marks an undefined icode.
  function automatic logic [3:0] instr_length(input logic [3:0] icode);
    case (icode)
      HALT, NOP, RET:              return 4'd1;
      RRMOVQ, OPQ, PUSHQ, POPQ:    return 4'd2;
      JXX, CALL:                   return 4'd9;
      IRMOVQ, RMMOVQ, MRMOVQ:      return 4'd10;
      default:                     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_len.sv
// Combinational icode decoder: instruction length, icode validity and whether a
// register-specifier byte follows the opcode byte.
module instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid,
  output logic       has_reg
);

  always_comb begin
    len     = instr_length(icode);
    valid   = (len != 4'd0);
    has_reg = 1'b0;
    case (icode)
      RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ: has_reg = 1'b1;
      default:                                          has_reg = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Y86-64 instruction encoder: serialises one instruction per acceptance into byte writes.
// Field legality checks are compiled in only when INSTR_ENC_REGCHK_EN is defined.
module instr_encoder
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 2048,
  parameter int unsigned ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              set_addr,
  input  logic [ADDR_W-1:0] new_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic {StIdle, StEmit} state_e;

  localparam logic [ADDR_W:0] Limit = (ADDR_W+1)'(IMEM_DEPTH);

  state_e          r_state, w_state_next;
  logic [ADDR_W:0] r_ptr;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]      r_idx, r_len;
  logic            r_has_reg;
  logic [7:0]      r_byte0, r_regs;
  logic [63:0]     r_valc;
  logic            r_err;
  err_code_e       r_err_code;

  logic            w_accept, w_icode_ok, w_has_reg, w_field_ok, w_last, w_is_valc;
  logic [3:0]      w_len;
  logic [ADDR_W:0] w_base, w_end;
  err_code_e       w_code;

  instr_len u_len (
    .icode   (icode),
    .len     (w_len),
    .valid   (w_icode_ok),
    .has_reg (w_has_reg)
  );

`ifdef INSTR_ENC_REGCHK_EN
  always_comb begin
    w_field_ok = (ifun == 4'h0);
    case (icode)
      IRMOVQ:      w_field_ok = (ifun == 4'h0) && (rA == RNONE);
      PUSHQ, POPQ: w_field_ok = (ifun == 4'h0) && (rB == RNONE);
      OPQ:         w_field_ok = (ifun <= 4'h3);
      JXX, RRMOVQ: w_field_ok = (ifun <= 4'h6);
      default:     ;
    endcase
  end
`else
  assign w_field_ok = 1'b1;
`endif

  assign in_ready = (r_state == StIdle) && !rst;
  assign w_accept = in_valid && in_ready;
  // A pending set_addr moves the base before the instruction is placed.
  assign w_base   = set_addr ? {1'b0, new_addr} : r_ptr;
  assign w_end    = w_base + {{(ADDR_W-3){1'b0}}, w_len};

  always_comb begin
    if (!w_icode_ok)      w_code = ErrIcode;
    else if (!w_field_ok) w_code = ErrField;
    else if (w_end > Limit) w_code = ErrOverflow;
    else                  w_code = ErrNone;
  end

  assign w_last    = (r_idx == r_len - 4'd1);
  assign w_is_valc = (r_idx != 4'd0) && !(r_has_reg && (r_idx == 4'd1));
  assign wr_addr   = r_base + {{(ADDR_W-4){1'b0}}, r_idx};

  always_comb begin
    w_state_next = r_state;
    wr_en        = 1'b0;
    done         = 1'b0;
    wr_data      = 8'h00;
    unique case (r_state)
      StIdle: if (w_accept && (w_code == ErrNone)) w_state_next = StEmit;
      StEmit: begin
        wr_en = 1'b1;
        if (r_idx == 4'd0)  wr_data = r_byte0;
        else if (w_is_valc) wr_data = r_valc[63:56];
        else                wr_data = r_regs;
        if (w_last) begin
          done         = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_base     <= '0;
      r_idx      <= '0;
      r_len      <= '0;
      r_has_reg  <= 1'b0;
      r_byte0    <= '0;
      r_regs     <= '0;
      r_valc     <= '0;
      r_err      <= 1'b0;
      r_err_code <= ErrNone;
    end else begin
      r_err      <= 1'b0;
      r_err_code <= ErrNone;
      if (r_state == StIdle) begin
        if (set_addr) r_ptr <= {1'b0, new_addr};
        if (w_accept) begin
          if (w_code != ErrNone) begin
            r_err      <= 1'b1;
            r_err_code <= w_code;
          end else begin
            r_base    <= w_base[ADDR_W-1:0];
            r_idx     <= '0;
            r_len     <= w_len;
            r_has_reg <= w_has_reg;
            r_byte0   <= {icode, ifun};
            r_regs    <= {rA, rB};
            r_valc    <= valC;
          end
        end
      end else begin
        r_idx <= r_idx + 4'd1;
        if (w_is_valc) r_valc <= {r_valc[55:0], 8'h00};
        // Pointer may land exactly on IMEM_DEPTH; the extra bit keeps it from wrapping.
        if (w_last) r_ptr <= {1'b0, r_base} + {{(ADDR_W-3){1'b0}}, r_len};
      end
    end
  end

  // A full memory is reported as the last address rather than wrapping to 0.
  assign wr_ptr   = r_ptr[ADDR_W] ? {ADDR_W{1'b1}} : r_ptr[ADDR_W-1:0];
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with immediate-assertion checks.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        set_addr;
  logic [10:0] new_addr;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [10:0] wr_ptr;
  logic        done, err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_irmov [10];

  instr_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .icode    (icode),
    .ifun     (ifun),
    .rA       (rA),
    .rB       (rB),
    .valC     (valC),
    .set_addr (set_addr),
    .new_addr (new_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ptr   (wr_ptr),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    set_addr = 1'b0;
  endtask

  task automatic give(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    icode    = ic;
    ifun     = fn;
    rA       = ra;
    rB       = rb;
    valC     = vc;
    in_valid = 1'b1;
  endtask

  initial begin
    exp_irmov = '{8'h30, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
    rst = 1'b1;
    in_valid = 1'b0; icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    set_addr = 1'b0; new_addr = '0;
    step();
    step();
    check("rst in_ready", in_ready, 0);
    check("rst wr_en", wr_en, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst err_code", err_code, 0);
    check("rst wr_ptr", wr_ptr, 0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 1);

    // irmovq $4, %rax; fields are scrambled and set_addr pulsed while emitting
    give(4'h3, 4'h0, 4'hF, 4'h0, 64'd4);
    step();
    in_valid = 1'b0; icode = 4'hC; rA = 4'h0; valC = '1; new_addr = 11'd500;
    for (int k = 0; k < 10; k++) begin
      check("irmovq wr_en", wr_en, 1);
      check("irmovq wr_addr", wr_addr, k);
      check("irmovq wr_data", wr_data, exp_irmov[k]);
      check("irmovq done", done, (k == 9));
      check("irmovq in_ready", in_ready, 0);
      set_addr = (k < 9);
      step();
    end
    check("irmovq end wr_en", wr_en, 0);
    check("irmovq end done", done, 0);
    check("irmovq wr_ptr", wr_ptr, 10);
    check("irmovq end in_ready", in_ready, 1);

    // nop then halt back-to-back
    give(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    step();
    check("nop wr_en", wr_en, 1);
    check("nop wr_addr", wr_addr, 10);
    check("nop wr_data", wr_data, 8'h10);
    check("nop done", done, 1);
    check("nop in_ready", in_ready, 0);
    give(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    step();
    check("gap in_ready", in_ready, 1);
    check("gap wr_en", wr_en, 0);
    step();
    idle_inputs();
    check("halt wr_en", wr_en, 1);
    check("halt wr_addr", wr_addr, 11);
    check("halt wr_data", wr_data, 8'h00);
    check("halt done", done, 1);
    check("halt in_ready", in_ready, 0);
    step();
    check("halt wr_ptr", wr_ptr, 12);
    check("halt end in_ready", in_ready, 1);

    // addq %rax,%rbx placed via coincident set_addr
    give(4'h6, 4'h0, 4'h0, 4'h3, 64'd0);
    set_addr = 1'b1; new_addr = 11'd23;
    step();
    idle_inputs();
    check("addq b0 wr_addr", wr_addr, 23);
    check("addq b0 wr_data", wr_data, 8'h60);
    check("addq b0 done", done, 0);
    step();
    check("addq b1 wr_addr", wr_addr, 24);
    check("addq b1 wr_data", wr_data, 8'h03);
    check("addq b1 done", done, 1);
    step();
    check("addq wr_en", wr_en, 0);
    check("addq wr_ptr", wr_ptr, 25);

    // Bad icode
    give(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
    step();
    idle_inputs();
    check("badicode err", err, 1);
    check("badicode err_code", err_code, 1);
    check("badicode wr_en", wr_en, 0);
    check("badicode wr_ptr", wr_ptr, 25);
    check("badicode in_ready", in_ready, 1);
    step();
    check("badicode err pulse", err, 0);

    // Overflow: jXX (9 bytes) at 2045
    set_addr = 1'b1; new_addr = 11'd2045;
    step();
    set_addr = 1'b0;
    check("setaddr wr_ptr", wr_ptr, 2045);
    give(4'h7, 4'h0, 4'hF, 4'hF, 64'h1234);
    step();
    idle_inputs();
    check("ovf err", err, 1);
    check("ovf err_code", err_code, 2);
    check("ovf wr_en", wr_en, 0);
    check("ovf wr_ptr", wr_ptr, 2045);
    step();
    check("ovf later wr_en", wr_en, 0);

    // rrmovq ending exactly at the last byte; memory is then full
    give(4'h2, 4'h0, 4'h1, 4'h2, 64'd0);
    set_addr = 1'b1; new_addr = 11'd2046;
    step();
    idle_inputs();
    check("fit err", err, 0);
    check("fit b0 wr_en", wr_en, 1);
    check("fit b0 wr_addr", wr_addr, 2046);
    check("fit b0 wr_data", wr_data, 8'h20);
    step();
    check("fit b1 wr_addr", wr_addr, 2047);
    check("fit b1 wr_data", wr_data, 8'h12);
    check("fit b1 done", done, 1);
    step();
    give(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    step();
    idle_inputs();
    check("full nop err", err, 1);
    check("full nop err_code", err_code, 2);
    check("full nop wr_en", wr_en, 0);

    // Reset while byte 4 of an irmovq is written
    give(4'h3, 4'h0, 4'hF, 4'h0, 64'd4);
    set_addr = 1'b1; new_addr = 11'd0;
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      check("abort pre wr_addr", wr_addr, k);
      step();
    end
    check("abort b4 wr_en", wr_en, 1);
    check("abort b4 wr_addr", wr_addr, 4);
    #1 rst = 1'b1;
    #1;
    check("abort wr_en", wr_en, 0);
    check("abort done", done, 0);
    check("abort wr_ptr", wr_ptr, 0);
    check("abort in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("abort release in_ready", in_ready, 1);
    step();
    check("abort no done", done, 0);
    check("abort no wr_en", wr_en, 0);

    // pushq with rB = 0
    give(4'hA, 4'h0, 4'h0, 4'h0, 64'd0);
    step();
    idle_inputs();
`ifdef INSTR_ENC_REGCHK_EN
    check("pushq err", err, 1);
    check("pushq err_code", err_code, 3);
    check("pushq wr_en", wr_en, 0);
    step();
    check("pushq wr_ptr", wr_ptr, 0);
`else
    check("pushq err", err, 0);
    check("pushq b0 wr_addr", wr_addr, 0);
    check("pushq b0 wr_data", wr_data, 8'hA0);
    step();
    check("pushq b1 wr_addr", wr_addr, 1);
    check("pushq b1 wr_data", wr_data, 8'h00);
    check("pushq b1 done", done, 1);
    step();
    check("pushq wr_ptr", wr_ptr, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
